img_window_buf: RTL
===================

// Module: img_window_buf
// PURPOSE
// Parametrised frame buffer plus sliding-window generator for the edge-detection pipeline.
// - Loads one IMG_DIM x IMG_DIM frame at PIX_PER_CYC pixels per beat, in raster order.
// - Streams KxK windows (K = 3 or 5, chosen at run time) to a filter stage over a valid/ready handshake.
// - Border handling is selectable: valid-only or edge-replicate.
// - Successor to the fixed 20x20, 5-pixel, single-pass loader; feeds the median, Gaussian and Sobel stages.
// PARAMETERS
// IMG_DIM      20  frame width = height, in pixels (>= 6)
// BIT_LENGTH    5  bits per pixel
// PIX_PER_CYC   5  pixels per load beat; IMG_DIM*IMG_DIM % PIX_PER_CYC == 0 (checked at elaboration)
// PORTS
// clk         in   1                   clock; all logic on the rising edge
// reset       in   1                   synchronous reset, active-low
// in_valid    in   1                   load beat valid
// in_ready    out  1                   buffer accepts a load beat
// pixel_in    in   PIX_PER_CYC*BIT_LENGTH  lane j = bits [j*BL+:BL], raster address base+j
// win_size    in   1                   0 = 3x3, 1 = 5x5; sampled on the final load beat
// border_mode in   1                   0 = valid-only, 1 = replicate; sampled on the final load beat
// win_valid   out  1                   window available
// win_ready   in   1                   consumer accepts the window
// win_out     out  25*BIT_LENGTH       5x5 tap array; tap (dr,dc), dr,dc in -2..2, at index (dr+2)*5+(dc+2)
// win_row     out  $clog2(IMG_DIM)     row of the window centre
// win_col     out  $clog2(IMG_DIM)     column of the window centre
// frame_done  out  1                   one-cycle pulse after the last window is accepted
// BEHAVIOUR
// - Reset (reset==0 at clk edge):
//   - state=LOAD; load address, row and column counters = 0; all buffer pixels = 0.
//   - in_ready, win_valid, frame_done = 0; win_out, win_row, win_col = 0.
// - States: LOAD -> SCAN -> DONE -> LOAD.
// - LOAD: in_ready=1 (forced 0 while reset==0).
//   - Each in_valid&&in_ready writes pixel_in lanes to addresses base..base+PIX_PER_CYC-1.
//   - base then advances by PIX_PER_CYC. in_valid gaps are allowed.
//   - The beat that writes address IMG_DIM^2-1 latches win_size and border_mode (R = 1 or 2), then moves to SCAN.
// - SCAN: in_ready=0; in_valid is ignored.
//   - win_valid=1 from the cycle after the final load beat, so first-window latency is 1 cycle.
//   - Centre range: valid-only covers rows and columns R..IMG_DIM-1-R, i.e. (IMG_DIM-2R)^2 windows.
//     Replicate covers 0..IMG_DIM-1, i.e. IMG_DIM^2 windows.
//   - Replicate clamps each tap coordinate to 0..IMG_DIM-1 independently per axis.
//   - When K=3, taps with |dr|==2 or |dc|==2 are driven 0.
//   - win_valid&&win_ready advances the centre in raster order (column first, then row).
//     The next window is valid on the next cycle: 1 window/cycle throughput.
//   - While win_ready==0, win_out, win_row and win_col stay stable and win_valid stays 1.
//   - Acceptance of the last centre moves to DONE.
// - DONE: one cycle; frame_done=1, win_valid=0, win_out=0; then LOAD with counters cleared.
//   - Buffer contents persist until overwritten.
// - win_out, win_row and win_col are 0 whenever win_valid==0.
// - Latched mode bits are unaffected by input changes during SCAN.
// - Reset in any state, including mid-beat or mid-stall, aborts the frame.
//   - Nothing partial is emitted and no frame_done is raised.
// - Tap pixel values pass through unmodified; no arithmetic.
// TESTING
// 1. Defaults; load pix[a] = a%32 in 80 beats; win_size=0, border_mode=0.
//    -> in_ready falls after beat 80; 324 windows.
//    -> First centre (1,1): tap(0,0)=21, tap(-1,-1)=0. Last centre (18,18): tap(0,0)=378%32=26.
//    -> frame_done exactly 1 cycle after the 324th accept.
// 2. Same image, win_size=1, border_mode=1.
//    -> 400 windows. Centre (0,0): tap(-2,-2)=0, tap(2,2)=42%32=10.
//    -> Centre (19,19): tap(2,2)=399%32=15.
// 3. win_size=1, border_mode=0.
//    -> 256 windows, centres 2..17. Ring taps nonzero; the K=3 test shows them zeroed.
// 4. Random win_ready backpressure.
//    -> Every window is emitted exactly once in raster order; outputs stable while stalled.
// 5. Random in_valid gaps and a lone idle beat before the last beat.
//    -> Buffer matches a gap-free load; first win_valid comes 1 cycle after the last beat.
// 6. reset=0 after 50 accepted windows.
//    -> win_valid=0 next cycle; after release, in_ready=1; a reload of a new image streams correctly.

Source files
------------

// File: rtl/img_window_buf.sv
// Frame buffer plus sliding-window generator for the edge-detection pipeline.
// A full IMG_DIM x IMG_DIM frame is loaded in raster order, PIX_PER_CYC pixels per beat,
// and is then scanned as 3x3 or 5x5 windows, one per accepted handshake.
//
// Ports:
//   clk, reset         rising-edge clock; synchronous active-low reset
//   in_valid/in_ready  load-beat handshake; pixel_in lane j holds raster address base+j
//   win_size           0 = 3x3, 1 = 5x5 (latched on the final load beat)
//   border_mode        0 = valid-only centres, 1 = edge-replicate (latched on the final beat)
//   win_valid/ready    window handshake
//   win_out            5x5 taps, tap (dr,dc) at index (dr+2)*5+(dc+2); zero when idle
//   win_row/win_col    centre coordinate of the presented window; zero when idle
//   frame_done         one-cycle pulse after the last window is accepted
module img_window_buf #(
  parameter int unsigned IMG_DIM     = 20,
  parameter int unsigned BIT_LENGTH  = 5,
  parameter int unsigned PIX_PER_CYC = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PIX_PER_CYC*BIT_LENGTH-1:0] pixel_in,
  input  logic                              win_size,
  input  logic                              border_mode,
  output logic                              win_valid,
  input  logic                              win_ready,
  output logic [25*BIT_LENGTH-1:0]          win_out,
  output logic [$clog2(IMG_DIM)-1:0]        win_row,
  output logic [$clog2(IMG_DIM)-1:0]        win_col,
  output logic                              frame_done
);

  localparam int unsigned NPix     = IMG_DIM * IMG_DIM;
  localparam int unsigned AW       = $clog2(NPix);
  localparam int unsigned CW       = $clog2(IMG_DIM);
  localparam int unsigned LastBase = NPix - PIX_PER_CYC;
  localparam int          MaxCoord = int'(IMG_DIM) - 1;

  if ((NPix % PIX_PER_CYC) != 0) begin : g_bad_ppc
    $error("IMG_DIM*IMG_DIM must be a multiple of PIX_PER_CYC");
  end
  if (IMG_DIM < 6) begin : g_bad_dim
    $error("IMG_DIM must be at least 6");
  end

  typedef enum logic [1:0] {StLoad, StScan, StDone} state_e;

  state_e                state_q, state_d;
  logic [BIT_LENGTH-1:0] mem_q [NPix];
  logic [AW-1:0]         base_q;
  logic [CW-1:0]         row_q, col_q;
  logic                  size_q, repl_q;

  logic          load_fire, win_fire, last_beat, last_win;
  logic [CW-1:0] start, lo, hi;

  assign load_fire = in_valid && in_ready;
  assign win_fire  = win_valid && win_ready;
  assign last_beat = (base_q == AW'(LastBase));
  // First centre for the frame being latched uses the live mode inputs.
  assign start     = border_mode ? '0 : (win_size ? CW'(2) : CW'(1));
  assign lo        = repl_q ? '0 : (size_q ? CW'(2) : CW'(1));
  assign hi        = repl_q ? CW'(MaxCoord) : CW'(MaxCoord) - (size_q ? CW'(2) : CW'(1));
  assign last_win  = (row_q == hi) && (col_q == hi);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StLoad;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    win_valid  = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StLoad: begin
        in_ready = reset;
        if (load_fire && last_beat) state_d = StScan;
      end
      StScan: begin
        win_valid = 1'b1;
        if (win_fire && last_win) state_d = StDone;
      end
      StDone: begin
        frame_done = 1'b1;
        state_d    = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      base_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      size_q <= 1'b0;
      repl_q <= 1'b0;
      for (int i = 0; i < int'(NPix); i++) mem_q[i] <= '0;
    end else begin
      if (load_fire) begin
        for (int j = 0; j < int'(PIX_PER_CYC); j++) begin
          mem_q[base_q + AW'(j)] <= pixel_in[j*BIT_LENGTH +: BIT_LENGTH];
        end
        base_q <= base_q + AW'(PIX_PER_CYC);
        if (last_beat) begin
          base_q <= '0;
          size_q <= win_size;
          repl_q <= border_mode;
          row_q  <= start;
          col_q  <= start;
        end
      end
      if (win_fire) begin
        if (col_q == hi) begin
          col_q <= lo;
          row_q <= row_q + CW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      if (state_q == StDone) begin
        base_q <= '0;
        row_q  <= '0;
        col_q  <= '0;
      end
    end
  end

  // Tap gather: coordinates are clamped per axis; in valid-only mode the centre range
  // keeps every tap in bounds, so the clamp only bites in replicate mode.
  int            tap_r, tap_c;
  logic [AW-1:0] tap_idx;

  always_comb begin
    win_out = '0;
    win_row = '0;
    win_col = '0;
    tap_r   = 0;
    tap_c   = 0;
    tap_idx = '0;
    if (state_q == StScan) begin
      win_row = row_q;
      win_col = col_q;
      for (int dr = -2; dr <= 2; dr++) begin
        for (int dc = -2; dc <= 2; dc++) begin
          if (size_q || (dr > -2 && dr < 2 && dc > -2 && dc < 2)) begin
            tap_r = int'(row_q) + dr;
            tap_c = int'(col_q) + dc;
            if (tap_r < 0) tap_r = 0;
            else if (tap_r > MaxCoord) tap_r = MaxCoord;
            if (tap_c < 0) tap_c = 0;
            else if (tap_c > MaxCoord) tap_c = MaxCoord;
            tap_idx = AW'(tap_r * int'(IMG_DIM) + tap_c);
            win_out[((dr+2)*5 + (dc+2))*BIT_LENGTH +: BIT_LENGTH] = mem_q[tap_idx];
          end
        end
      end
    end
  end

endmodule
